multi_clock_divider: RTL and testbench
======================================

MULTI_CLOCK_DIVIDER -- requirements
Module: multi_clock_divider

Interface
REQ-001 SHALL have parameter NCH, default 4, number of independent divider channels (1..16).
REQ-002 SHALL have parameter BW, default 8, counter/setting width per channel (2..16).
REQ-003 SHALL have port Clock  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port ResetN  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port Enable  input  NCH  per-channel run enable.
REQ-006 SHALL have port Divisor  input  NCH*BW  per-channel terminal count D; channel c in bits [c*BW +: BW]; period = D+1 Clock cycles.
REQ-007 SHALL have port HighTime  input  NCH*BW  per-channel high-phase length H, same packing.
REQ-008 SHALL have port Sync  input  1  single-cycle strobe realigning all enabled channels.
REQ-009 SHALL have port OutClock  output  NCH  registered divided clock per channel.
REQ-010 SHALL have port Tick  output  NCH  registered one-cycle pulse at each period start.

Function
REQ-011 Each channel SHALL hold a BW-bit Count and active copies ActD, ActH of Divisor/HighTime.
REQ-012 Enabled channel: Count SHALL advance 0,1,..,ActD, then wrap to 0; the wrap is unsigned, no overflow possible.
REQ-013 OutClock[c] SHALL be registered (NextCount < NextH); H=0 -> constant 0, H>D -> constant 1.
REQ-014 Tick[c] SHALL be 1 exactly in cycles where registered Count==0 and channel enabled.
REQ-015 ActD/ActH SHALL reload from inputs only when Count==ActD (period end), when Enable[c]=0, or on Sync; mid-period input changes SHALL NOT alter the current period (glitch-free update).
REQ-016 D=0 SHALL give Count held at 0, Tick constant 1, OutClock = (H>0).
REQ-017 Enable[c]=0 SHALL force Count=0, OutClock[c]=0, Tick[c]=0 at the next edge; first edge with Enable=1 SHALL yield Count=0, Tick=1, OutClock=(H>0).
REQ-018 Sync=1 SHALL, at the next edge, set Count of every enabled channel to its start value (0, or phase per REQ-024), reload ActD/ActH, assert Tick; Sync SHALL take priority over period-end wrap.
REQ-019 Sync with Enable[c]=0 SHALL have no effect on channel c.
REQ-020 Channels SHALL be fully independent except for shared Sync.

Reset
REQ-021 ResetN=0 SHALL asynchronously clear Count, ActD, ActH, OutClock and Tick of all channels to 0.
REQ-022 After ResetN deasserts, the first rising edge SHALL behave as REQ-017 enable-start for enabled channels.
REQ-023 Reset asserted mid-period SHALL discard the period; no partial high pulse after release.

Configuration
REQ-024 With MULTI_CLOCK_DIVIDER_PHASE_EN defined: input Phase NCH*BW added; Sync and enable-start SHALL load Count = min(Phase[c], ActD) with OutClock/Tick derived from that Count.
REQ-025 Without MULTI_CLOCK_DIVIDER_PHASE_EN: no Phase port; start value SHALL always be 0.

Structure
REQ-026 Package mcd_pkg SHALL hold BW/NCH defaults, range limits and the start-value constant.
REQ-027 Per-channel logic SHALL be sub-module mcd_channel, instantiated NCH times by generate; top holds only Sync fan-out and bus slicing.

Verification
REQ-028 NCH=4,BW=8; ch0 D=3,H=2 -> OutClock 1,1,0,0 repeating; Tick every 4th cycle aligned with first high cycle.
REQ-029 ch1 D=4,H=2 running; change to D=1,H=1 at Count=2 -> current period completes as 11000, then 10 repeating.
REQ-030 ch0 D=3, ch1 D=5 free-running, pulse Sync -> next cycle both Tick=1, both OutClock=1, Counts 0.
REQ-031 H=0 -> OutClock stuck 0; H=9 with D=7 -> OutClock stuck 1; D=0,H=1 -> Tick and OutClock constant 1.
REQ-032 ResetN low at Count=1 of D=3 -> all outputs 0 immediately (asynchronous); after release, first edge Tick=1.
REQ-033 With MULTI_CLOCK_DIVIDER_PHASE_EN, D=3,H=2,Phase=2, Sync -> OutClock 0,0,1,1 repeating, Tick on 3rd cycle after Sync; Phase=9 clamps to Count=3.

Source files
------------

// File: rtl/multi_clock_divider_pkg.sv
// ---------------------------------------------------------------------------
// mcd_pkg -- shared constants for the multi-channel clock divider.
//   NCH_DEFAULT / BW_DEFAULT : default channel count and counter width
//   *_MIN / *_MAX            : supported parameter ranges
//   START_COUNT              : counter value loaded on enable-start and Sync
//                              when phase offsets are not built in
// Optional feature macro used by the design: MULTI_CLOCK_DIVIDER_PHASE_EN
// ---------------------------------------------------------------------------
package mcd_pkg;
    localparam int unsigned NCH_DEFAULT = 4;
    localparam int unsigned BW_DEFAULT  = 8;
    localparam int unsigned NCH_MIN     = 1;
    localparam int unsigned NCH_MAX     = 16;
    localparam int unsigned BW_MIN      = 2;
    localparam int unsigned BW_MAX      = 16;
    localparam int unsigned START_COUNT = 0;
endpackage

// File: rtl/multi_clock_divider_if.sv
// ---------------------------------------------------------------------------
// multi_clock_divider_if -- per-channel divider bus.
//   enable     : channel run enable
//   divisor    : terminal count D (period = D+1 cycles)
//   high_time  : high-phase length H
//   sync       : realignment strobe
//   phase      : start offset (only with MULTI_CLOCK_DIVIDER_PHASE_EN)
//   out_clock  : registered divided clock
//   tick       : registered period-start pulse
// master drives the controls, slave is the divider channel.
// ---------------------------------------------------------------------------
interface multi_clock_divider_if #(
    parameter int unsigned BW = 8
);
    logic          enable;
    logic          sync;
    logic [BW-1:0] divisor;
    logic [BW-1:0] high_time;
`ifdef MULTI_CLOCK_DIVIDER_PHASE_EN
    logic [BW-1:0] phase;
`endif
    logic          out_clock;
    logic          tick;

`ifdef MULTI_CLOCK_DIVIDER_PHASE_EN
    modport master (output enable, sync, divisor, high_time, phase,
                    input  out_clock, tick);
    modport slave  (input  enable, sync, divisor, high_time, phase,
                    output out_clock, tick);
`else
    modport master (output enable, sync, divisor, high_time,
                    input  out_clock, tick);
    modport slave  (input  enable, sync, divisor, high_time,
                    output out_clock, tick);
`endif
endinterface

// File: rtl/multi_clock_divider_channel.sv
// ---------------------------------------------------------------------------
// mcd_channel -- one divider channel.
//   clk, rst_n : clock, asynchronous active-low reset
//   ch         : slave side of multi_clock_divider_if
// Count runs 0..ActD and wraps; ActD/ActH are the settings in force for the
// current period and only reload at period end, while disabled, or on
// enable-start/Sync, so mid-period input changes never produce a glitch.
// With MULTI_CLOCK_DIVIDER_PHASE_EN the start value is min(phase, divisor).
// ---------------------------------------------------------------------------
module mcd_channel
    import mcd_pkg::*;
#(
    parameter int unsigned BW = BW_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    multi_clock_divider_if.slave ch
);
    logic [BW-1:0] count, act_d, act_h;
    logic [BW-1:0] count_n, act_d_n, act_h_n, start_val;
    logic          run, start, period_end;
    logic          out_q, tick_q;

    assign period_end = (count == act_d);
    // run remembers whether the previous edge saw the channel enabled, so the
    // first enabled edge (including the first after reset) is a fresh start.
    assign start      = ch.enable && (!run || ch.sync);

`ifdef MULTI_CLOCK_DIVIDER_PHASE_EN
    assign start_val = (ch.phase > ch.divisor) ? ch.divisor : ch.phase;
`else
    assign start_val = BW'(START_COUNT);
`endif

    always_comb begin
        act_d_n = act_d;
        act_h_n = act_h;
        count_n = count + BW'(1);
        if (!ch.enable || start || period_end) begin
            act_d_n = ch.divisor;
            act_h_n = ch.high_time;
        end
        if (!ch.enable) begin
            count_n = '0;
        end else if (start) begin
            count_n = start_val;
        end else if (period_end) begin
            count_n = '0;
        end
    end

    // Outputs are computed from the next-state values so they line up with
    // the registered count in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            act_d  <= '0;
            act_h  <= '0;
            run    <= 1'b0;
            out_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            count  <= count_n;
            act_d  <= act_d_n;
            act_h  <= act_h_n;
            run    <= ch.enable;
            out_q  <= ch.enable && (count_n < act_h_n);
            tick_q <= ch.enable && (count_n == '0);
        end
    end

    assign ch.out_clock = out_q;
    assign ch.tick      = tick_q;
endmodule

// File: rtl/multi_clock_divider.sv
// ---------------------------------------------------------------------------
// multi_clock_divider -- NCH independent programmable clock dividers.
//   Clock     : sole clock, rising edge
//   ResetN    : asynchronous active-low reset
//   Enable    : per-channel run enable [NCH]
//   Divisor   : per-channel terminal count, channel c at [c*BW +: BW]
//   HighTime  : per-channel high-phase length, same packing
//   Sync      : one-cycle strobe realigning all enabled channels
//   Phase     : per-channel start offset (MULTI_CLOCK_DIVIDER_PHASE_EN only)
//   OutClock  : registered divided clocks [NCH]
//   Tick      : registered period-start pulses [NCH]
// Top level only slices the buses and fans Sync out to the channels.
// ---------------------------------------------------------------------------
module multi_clock_divider
    import mcd_pkg::*;
#(
    parameter int unsigned NCH = NCH_DEFAULT,
    parameter int unsigned BW  = BW_DEFAULT
) (
    input  logic              Clock,
    input  logic              ResetN,
    input  logic [NCH-1:0]    Enable,
    input  logic [NCH*BW-1:0] Divisor,
    input  logic [NCH*BW-1:0] HighTime,
    input  logic              Sync,
`ifdef MULTI_CLOCK_DIVIDER_PHASE_EN
    input  logic [NCH*BW-1:0] Phase,
`endif
    output logic [NCH-1:0]    OutClock,
    output logic [NCH-1:0]    Tick
);
    for (genvar c = 0; c < NCH; c++) begin : g_ch
        multi_clock_divider_if #(.BW(BW)) ch_bus ();

        assign ch_bus.enable    = Enable[c];
        assign ch_bus.sync      = Sync;
        assign ch_bus.divisor   = Divisor[c*BW +: BW];
        assign ch_bus.high_time = HighTime[c*BW +: BW];
`ifdef MULTI_CLOCK_DIVIDER_PHASE_EN
        assign ch_bus.phase     = Phase[c*BW +: BW];
`endif
        assign OutClock[c]      = ch_bus.out_clock;
        assign Tick[c]          = ch_bus.tick;

        mcd_channel #(.BW(BW)) u_channel (
            .clk   (Clock),
            .rst_n (ResetN),
            .ch    (ch_bus)
        );
    end
endmodule

// File: tb/tb_multi_clock_divider.sv
// ---------------------------------------------------------------------------
// tb_multi_clock_divider -- self-checking bench for multi_clock_divider.
// The reference model tracks, per channel, the cycle on which the current
// period started and the settings latched for it; outputs follow from the
// elapsed cycle count. Build with MULTI_CLOCK_DIVIDER_PHASE_EN to add the
// phase-offset scenario.
// ---------------------------------------------------------------------------
module tb_multi_clock_divider;
    localparam int unsigned NCH = 4;
    localparam int unsigned BW  = 8;

    logic              Clock = 1'b0;
    logic              ResetN;
    logic [NCH-1:0]    Enable;
    logic [NCH*BW-1:0] Divisor;
    logic [NCH*BW-1:0] HighTime;
    logic              Sync;
`ifdef MULTI_CLOCK_DIVIDER_PHASE_EN
    logic [NCH*BW-1:0] Phase;
`endif
    logic [NCH-1:0]    OutClock;
    logic [NCH-1:0]    Tick;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // reference model state
    bit             m_run [NCH];
    int             m_t0  [NCH];
    int             m_d   [NCH];
    int             m_h   [NCH];
    logic [NCH-1:0] exp_out;
    logic [NCH-1:0] exp_tick;

    always #5 Clock = ~Clock;

    multi_clock_divider #(.NCH(NCH), .BW(BW)) dut (
        .Clock    (Clock),
        .ResetN   (ResetN),
        .Enable   (Enable),
        .Divisor  (Divisor),
        .HighTime (HighTime),
        .Sync     (Sync),
`ifdef MULTI_CLOCK_DIVIDER_PHASE_EN
        .Phase    (Phase),
`endif
        .OutClock (OutClock),
        .Tick     (Tick)
    );

    // channel 0 viewed through the channel bus interface
    multi_clock_divider_if #(.BW(BW)) ch0_view ();
    assign ch0_view.enable    = Enable[0];
    assign ch0_view.sync      = Sync;
    assign ch0_view.divisor   = Divisor[BW-1:0];
    assign ch0_view.high_time = HighTime[BW-1:0];
`ifdef MULTI_CLOCK_DIVIDER_PHASE_EN
    assign ch0_view.phase     = Phase[BW-1:0];
`endif
    assign ch0_view.out_clock = OutClock[0];
    assign ch0_view.tick      = Tick[0];

    task automatic set_ch(input int c, input int d, input int h);
        Divisor[c*BW +: BW]  = BW'(d);
        HighTime[c*BW +: BW] = BW'(h);
    endtask

    // Advance one clock and update the model from the inputs seen at the edge.
    task automatic step();
        @(posedge Clock);
        cyc++;
        for (int c = 0; c < NCH; c++) begin
            int d_in;
            int h_in;
            int s;
            d_in = int'(Divisor[c*BW +: BW]);
            h_in = int'(HighTime[c*BW +: BW]);
            s    = 0;
`ifdef MULTI_CLOCK_DIVIDER_PHASE_EN
            s = int'(Phase[c*BW +: BW]);
            if (s > d_in) s = d_in;
`endif
            if (!ResetN || !Enable[c]) begin
                m_run[c] = 1'b0;
            end else if (!m_run[c] || Sync) begin
                m_run[c] = 1'b1;
                m_d[c]   = d_in;
                m_h[c]   = h_in;
                m_t0[c]  = cyc - s;
            end else if (cyc - m_t0[c] > m_d[c]) begin
                m_d[c]   = d_in;
                m_h[c]   = h_in;
                m_t0[c]  = cyc;
            end
            exp_out[c]  = m_run[c] && ((cyc - m_t0[c]) < m_h[c]);
            exp_tick[c] = m_run[c] && ((cyc - m_t0[c]) == 0);
        end
        #1;
    endtask

    task automatic test_reset();
        ResetN   = 1'b0;
        Enable   = '0;
        Sync     = 1'b0;
        Divisor  = '0;
        HighTime = '0;
`ifdef MULTI_CLOCK_DIVIDER_PHASE_EN
        Phase    = '0;
`endif
        for (int c = 0; c < NCH; c++) m_run[c] = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        checks++;
        if (OutClock !== '0) begin
            failures++;
            $display("FAIL reset_outclock got=%b exp=%b", OutClock, {NCH{1'b0}});
        end
        checks++;
        if (Tick !== '0) begin
            failures++;
            $display("FAIL reset_tick got=%b exp=%b", Tick, {NCH{1'b0}});
        end
        @(negedge Clock);
        ResetN = 1'b1;
    endtask

    task automatic test_basic();
        logic [3:0] pat;
        pat = 4'b0011;
        set_ch(0, 3, 2);
        Enable = 4'b0001;
        for (int k = 0; k < 12; k++) begin
            step();
            checks++;
            if (OutClock !== exp_out) begin
                failures++;
                $display("FAIL basic_out cyc=%0d got=%b exp=%b", cyc, OutClock, exp_out);
            end
            checks++;
            if (Tick !== exp_tick) begin
                failures++;
                $display("FAIL basic_tick cyc=%0d got=%b exp=%b", cyc, Tick, exp_tick);
            end
            checks++;
            if (ch0_view.out_clock !== pat[k%4] || ch0_view.tick !== (k % 4 == 0)) begin
                failures++;
                $display("FAIL basic_pattern k=%0d got=%b%b exp=%b%b", k, ch0_view.out_clock,
                         ch0_view.tick, pat[k%4], (k % 4 == 0));
            end
        end
    endtask

    task automatic test_glitch_free();
        logic [5:0] seq;
        int         guard;
        set_ch(1, 4, 2);
        Enable[1] = 1'b1;
        guard = 0;
        step();
        while ((cyc - m_t0[1]) != 2 && guard < 20) begin
            checks++;
            if (OutClock !== exp_out || Tick !== exp_tick) begin
                failures++;
                $display("FAIL glitch_pre cyc=%0d got=%b/%b exp=%b/%b", cyc, OutClock, Tick, exp_out, exp_tick);
            end
            step();
            guard++;
        end
        checks++;
        if (guard >= 20) begin
            failures++;
            $display("FAIL glitch_wait got=timeout exp=count2");
        end
        set_ch(1, 1, 1);
        seq = '0;
        for (int k = 0; k < 6; k++) begin
            step();
            checks++;
            if (OutClock !== exp_out || Tick !== exp_tick) begin
                failures++;
                $display("FAIL glitch_model cyc=%0d got=%b/%b exp=%b/%b", cyc, OutClock, Tick, exp_out, exp_tick);
            end
            seq = {seq[4:0], OutClock[1]};
        end
        checks++;
        if (seq !== 6'b001010) begin
            failures++;
            $display("FAIL glitch_sequence got=%b exp=%b", seq, 6'b001010);
        end
    endtask

    task automatic test_sync();
        set_ch(0, 3, 2);
        set_ch(1, 5, 3);
        Enable = 4'b0011;
        for (int r = 0; r < 3; r++) begin
            int n;
            n = int'($urandom_range(9, 3));
            repeat (n) begin
                step();
                checks++;
                if (OutClock !== exp_out || Tick !== exp_tick) begin
                    failures++;
                    $display("FAIL sync_run cyc=%0d got=%b/%b exp=%b/%b", cyc, OutClock, Tick, exp_out, exp_tick);
                end
            end
            Sync = 1'b1;
            step();
            Sync = 1'b0;
            checks++;
            if ({Tick[1:0], OutClock[1:0]} !== 4'b1111 || Tick[2] !== 1'b0) begin
                failures++;
                $display("FAIL sync_align cyc=%0d got=%b/%b exp=011/x11", cyc, Tick[2:0], OutClock[1:0]);
            end
            checks++;
            if (OutClock !== exp_out || Tick !== exp_tick) begin
                failures++;
                $display("FAIL sync_model cyc=%0d got=%b/%b exp=%b/%b", cyc, OutClock, Tick, exp_out, exp_tick);
            end
        end
    endtask

    task automatic test_edge_cases();
        Enable = '0;
        step();
        checks++;
        if ({OutClock, Tick} !== '0) begin
            failures++;
            $display("FAIL disable_zero got=%b/%b exp=0/0", OutClock, Tick);
        end
        set_ch(0, 0, 1);
        set_ch(1, 6, 3);
        set_ch(2, 5, 0);
        set_ch(3, 7, 9);
        Enable = '1;
        for (int k = 0; k < 16; k++) begin
            step();
            checks++;
            if (OutClock !== exp_out || Tick !== exp_tick) begin
                failures++;
                $display("FAIL edge_model cyc=%0d got=%b/%b exp=%b/%b", cyc, OutClock, Tick, exp_out, exp_tick);
            end
            checks++;
            if ({OutClock[3], OutClock[2], OutClock[0], Tick[0]} !== 4'b1011) begin
                failures++;
                $display("FAIL edge_const cyc=%0d got=%b exp=1011", cyc,
                         {OutClock[3], OutClock[2], OutClock[0], Tick[0]});
            end
        end
    endtask

    task automatic test_reset_mid();
        int guard;
        Enable = 4'b0000;
        step();
        set_ch(0, 3, 2);
        Enable = 4'b0001;
        guard = 0;
        step();
        while ((cyc - m_t0[0]) != 1 && guard < 20) begin
            step();
            guard++;
        end
        checks++;
        if (guard >= 20 || OutClock[0] !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_pre got=%b guard=%0d exp=1", OutClock[0], guard);
        end
        #2;
        ResetN = 1'b0;
        for (int c = 0; c < NCH; c++) m_run[c] = 1'b0;
        #1;
        checks++;
        if (OutClock !== '0 || Tick !== '0) begin
            failures++;
            $display("FAIL rstmid_async got=%b/%b exp=0/0", OutClock, Tick);
        end
        #2;
        ResetN = 1'b1;
        step();
        checks++;
        if (Tick[0] !== 1'b1 || OutClock[0] !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_restart got=%b/%b exp=1/1", Tick[0], OutClock[0]);
        end
        for (int k = 0; k < 6; k++) begin
            step();
            checks++;
            if (OutClock !== exp_out || Tick !== exp_tick) begin
                failures++;
                $display("FAIL rstmid_model cyc=%0d got=%b/%b exp=%b/%b", cyc, OutClock, Tick, exp_out, exp_tick);
            end
        end
    endtask

`ifdef MULTI_CLOCK_DIVIDER_PHASE_EN
    task automatic test_phase();
        logic [3:0] pat;
        pat = 4'b1100;
        set_ch(0, 3, 2);
        Enable = 4'b0001;
        Phase  = '0;
        Phase[BW-1:0] = BW'(2);
        step();
        step();
        Sync = 1'b1;
        step();
        Sync = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) step();
            checks++;
            if (OutClock[0] !== pat[k%4] || Tick[0] !== (k % 4 == 2)) begin
                failures++;
                $display("FAIL phase_pattern k=%0d got=%b/%b exp=%b/%b", k, OutClock[0], Tick[0],
                         pat[k%4], (k % 4 == 2));
            end
            checks++;
            if (OutClock !== exp_out || Tick !== exp_tick) begin
                failures++;
                $display("FAIL phase_model cyc=%0d got=%b/%b exp=%b/%b", cyc, OutClock, Tick, exp_out, exp_tick);
            end
        end
        Phase[BW-1:0] = BW'(9);
        Sync = 1'b1;
        step();
        Sync = 1'b0;
        checks++;
        if (Tick[0] !== 1'b0 || OutClock[0] !== 1'b0) begin
            failures++;
            $display("FAIL phase_clamp got=%b/%b exp=0/0", Tick[0], OutClock[0]);
        end
        step();
        checks++;
        if (Tick[0] !== 1'b1 || OutClock[0] !== 1'b1) begin
            failures++;
            $display("FAIL phase_clamp_wrap got=%b/%b exp=1/1", Tick[0], OutClock[0]);
        end
        Phase = '0;
    endtask
`endif

    task automatic test_random();
        for (int c = 0; c < NCH; c++) set_ch(c, int'($urandom_range(12, 0)), int'($urandom_range(14, 0)));
        Enable = '1;
        for (int k = 0; k < 400; k++) begin
            int c;
            c = int'($urandom_range(NCH - 1, 0));
            if ($urandom_range(7, 0) == 0)
                set_ch(c, int'($urandom_range(12, 0)), int'($urandom_range(14, 0)));
            if ($urandom_range(15, 0) == 0)
                Enable[c] = ~Enable[c];
`ifdef MULTI_CLOCK_DIVIDER_PHASE_EN
            if ($urandom_range(15, 0) == 0)
                Phase[c*BW +: BW] = BW'($urandom_range(15, 0));
`endif
            Sync = ($urandom_range(19, 0) == 0);
            step();
            checks++;
            if (OutClock !== exp_out || Tick !== exp_tick) begin
                failures++;
                $display("FAIL random_model cyc=%0d got=%b/%b exp=%b/%b", cyc, OutClock, Tick, exp_out, exp_tick);
            end
        end
        Sync = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch_free();
        test_sync();
        test_edge_cases();
        test_reset_mid();
`ifdef MULTI_CLOCK_DIVIDER_PHASE_EN
        test_phase();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
